// File: rtl/lms_adapt_if.sv
// lms_adapt_if: sample handshake, results and weight readback for lms_adapt_core
interface lms_adapt_if #(
  parameter int DW = 16,
  parameter int TAPS = 16
);
  logic in_valid, in_ready, adapt_en, w_clr, out_valid;
  logic signed [DW-1:0] x_in, d_in, y_out, e_out, coef_data;
  logic [$clog2(TAPS)-1:0] coef_addr;
  modport master (
    output in_valid, x_in, d_in, adapt_en, w_clr, coef_addr,
    input in_ready, out_valid, y_out, e_out, coef_data
  );
  modport slave (
    input in_valid, x_in, d_in, adapt_en, w_clr, coef_addr,
    output in_ready, out_valid, y_out, e_out, coef_data
  );
endinterface

// File: rtl/lms_adapt_core.sv
// lms_adapt_core: sample-serial LMS adaptive FIR, one MAC per cycle for filtering and weight update
module lms_adapt_core #(
  parameter int DW = 16,
  parameter int TAPS = 16,
  parameter int MU_SHIFT = 8
) (
  input logic clk,
  input logic rst_btn,
  lms_adapt_if.slave bus
);
  localparam int AW = $clog2(TAPS);
  localparam int ACW = 2 * DW + AW;
  localparam logic signed [ACW-1:0] sat_hi = {{(ACW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACW-1:0] sat_lo = ~sat_hi;
  typedef logic signed [2*DW-1:0] prod_t;
  typedef enum logic [2:0] {IDLE, FILTER, ERR, UPDATE, DONE} state_t;
  state_t state, nxt;
  logic [AW-1:0] k;
  logic signed [DW-1:0] w [TAPS];
  logic signed [DW-1:0] x [TAPS];
  logic signed [DW-1:0] d_r, y_r, e_r, y_c, e_c, y_o, e_o, c_o, w_new;
  logic signed [ACW-1:0] acc;
  prod_t mac, upd;
  logic adapt_r, last, accept;

  function automatic logic signed [DW-1:0] sat(input logic signed [ACW-1:0] v);
    return v > sat_hi ? sat_hi[DW-1:0] : v < sat_lo ? sat_lo[DW-1:0] : v[DW-1:0];
  endfunction

  assign last = k == AW'(TAPS - 1);
  assign accept = bus.in_valid && bus.in_ready;
  assign mac = prod_t'(w[k]) * prod_t'(x[k]);
  assign upd = (prod_t'(e_r) * prod_t'(x[k])) >>> (DW - 1 + MU_SHIFT);
  assign w_new = sat(ACW'(w[k]) + ACW'(upd));
  assign y_c = sat(acc >>> (DW - 1));
  assign e_c = sat(ACW'(d_r) - ACW'(y_c));
  // w_clr takes the IDLE cycle for itself, so no sample is accepted alongside it
  assign bus.in_ready = state == IDLE && !rst_btn && !bus.w_clr;
  assign bus.out_valid = state == DONE;
  assign bus.y_out = y_o;
  assign bus.e_out = e_o;
  assign bus.coef_data = c_o;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = accept ? FILTER : IDLE;
      FILTER: nxt = last ? ERR : FILTER;
      ERR: nxt = adapt_r ? UPDATE : DONE;
      UPDATE: nxt = last ? DONE : UPDATE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (rst_btn) begin
      state <= IDLE;
      k <= '0;
      acc <= '0;
      d_r <= '0;
      y_r <= '0;
      e_r <= '0;
      adapt_r <= 1'b0;
      y_o <= '0;
      e_o <= '0;
      c_o <= '0;
      for (int i = 0; i < TAPS; i++) begin
        w[i] <= '0;
        x[i] <= '0;
      end
    end else begin
      state <= nxt;
      c_o <= w[bus.coef_addr];
      k <= (state == FILTER || state == UPDATE) && !last ? k + AW'(1) : '0;
      if (state == IDLE && bus.w_clr)
        for (int i = 0; i < TAPS; i++) w[i] <= '0;
      if (accept) begin
        for (int i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
        x[0] <= bus.x_in;
        d_r <= bus.d_in;
        adapt_r <= bus.adapt_en;
        acc <= '0;
      end
      if (state == FILTER) acc <= acc + ACW'(mac);
      if (state == ERR) begin
        y_r <= y_c;
        e_r <= e_c;
      end
      if (state == UPDATE) w[k] <= w_new;
      // results change only on entry to DONE so they hold across the next sample's ERR
      if (nxt == DONE) begin
        y_o <= state == ERR ? y_c : y_r;
        e_o <= state == ERR ? e_c : e_r;
      end
    end
endmodule

// File: tb/tb_lms_adapt_core.sv
// tb_lms_adapt_core: directed checks of an MU_SHIFT=1 core (a) and an MU_SHIFT=0 core (b), both TAPS=4
module tb_lms_adapt_core;
  logic clk = 0, rst = 1, sel = 0, in_valid = 0, adapt_en = 0, w_clr = 0;
  logic [15:0] x_in = 0, d_in = 0;
  logic [1:0] coef_addr = 0;
  int n_chk = 0, n_pass = 0;
  logic [15:0] cx [5] = '{16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h8000};
  logic [15:0] cd [5] = '{16'h7fff, 16'h8000, 16'h8000, 16'h8000, 16'h7fff};
  logic [15:0] cy [5] = '{16'h0000, 16'h7ffd, 16'h8001, 16'h8000, 16'h8002};
  logic [15:0] ce [5] = '{16'h7fff, 16'h8000, 16'hffff, 16'h0000, 16'h7fff};
  logic [15:0] sy [4] = '{16'h0000, 16'h7ffd, 16'h7fff, 16'h7fff};
  logic [15:0] se [4] = '{16'h7fff, 16'h0002, 16'h0000, 16'h0000};
  logic [15:0] sw [4] = '{16'h7ffe, 16'h7fff, 16'h7fff, 16'h7fff};

  lms_adapt_if #(.DW(16), .TAPS(4)) ia ();
  lms_adapt_if #(.DW(16), .TAPS(4)) ib ();
  lms_adapt_core #(.DW(16), .TAPS(4), .MU_SHIFT(1)) u_a (.clk(clk), .rst_btn(rst), .bus(ia.slave));
  lms_adapt_core #(.DW(16), .TAPS(4), .MU_SHIFT(0)) u_b (.clk(clk), .rst_btn(rst), .bus(ib.slave));

  assign ia.in_valid = in_valid;
  assign ib.in_valid = in_valid;
  assign ia.x_in = x_in;
  assign ib.x_in = x_in;
  assign ia.d_in = d_in;
  assign ib.d_in = d_in;
  assign ia.adapt_en = adapt_en;
  assign ib.adapt_en = adapt_en;
  assign ia.w_clr = w_clr;
  assign ib.w_clr = w_clr;
  assign ia.coef_addr = coef_addr;
  assign ib.coef_addr = coef_addr;

  wire rdy = sel ? ib.in_ready : ia.in_ready;
  wire ov = sel ? ib.out_valid : ia.out_valid;
  wire [15:0] yo = sel ? ib.y_out : ia.y_out;
  wire [15:0] eo = sel ? ib.e_out : ia.e_out;
  wire [15:0] cdat = sel ? ib.coef_data : ia.coef_data;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_rst(input int n);
    rst = 1;
    repeat (n) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic run(input logic [15:0] xv, input logic [15:0] dv, input logic a,
                     output int lat, output logic [15:0] yv, output logic [15:0] ev);
    int n;
    x_in = xv;
    d_in = dv;
    adapt_en = a;
    in_valid = 1;
    n = 0;
    @(negedge clk);
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov && lat < 100);
    yv = yo;
    ev = eo;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] addr, output logic [15:0] v);
    coef_addr = addr;
    @(posedge clk);
    @(negedge clk);
    v = cdat;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_w(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] v;
    logic [15:0] ex [4];
    ex = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      chk($sformatf("%s_w%0d", tag, i), v, ex[i]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int lat, n_acc, n_ov, last_acc, bad_gap;
    logic [15:0] y, e, v;
    rst = 1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", ov, 0);
    chk("rst_y", yo, 0);
    chk("rst_e", eo, 0);
    chk("rst_coef", cdat, 0);
    chk("rst_in_ready", rdy, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rel_in_ready", rdy, 1);
    @(posedge clk);
    #1;

    run(16'h4000, 16'h4000, 1, lat, y, e);
    chk("upd_lat", lat, 10);
    chk("upd_y", y, 16'h0000);
    chk("upd_e", e, 16'h4000);
    chk_w("upd", 16'h1000, 0, 0, 0);

    w_clr = 1;
    in_valid = 1;
    @(negedge clk);
    chk("wclr_in_ready", rdy, 0);
    @(posedge clk);
    #1 w_clr = 0;
    in_valid = 0;
    @(negedge clk);
    chk("wclr_no_accept", rdy, 1);
    @(posedge clk);
    #1;
    chk_w("wclr", 0, 0, 0, 0);

    do_rst(2);
    run(16'h4000, 16'h4000, 0, lat, y, e);
    chk("frz_lat", lat, 6);
    chk("frz_y", y, 16'h0000);
    chk("frz_e", e, 16'h4000);
    chk_w("frz", 0, 0, 0, 0);
    chk("frz_hold_e", eo, 16'h4000);

    do_rst(2);
    x_in = 16'h4000;
    d_in = 16'h4000;
    adapt_en = 1;
    in_valid = 1;
    n_acc = 0;
    n_ov = 0;
    last_acc = -1;
    bad_gap = 0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (in_valid && rdy) begin
        if (last_acc >= 0 && c - last_acc != 11) bad_gap++;
        last_acc = c;
        n_acc++;
      end
      if (ov) n_ov++;
      @(posedge clk);
      #1;
      if (c == 59) in_valid = 0;
    end
    chk("b2b_accepts", n_acc, 6);
    chk("b2b_gap_errors", bad_gap, 0);
    chk("b2b_out_count", n_ov, n_acc);

    in_valid = 1;
    n_ov = 0;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (6) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    if (ov) n_ov++;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midrst_idle", rdy, 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ov) n_ov++;
    end
    @(posedge clk);
    #1;
    chk("midrst_no_out", n_ov, 0);
    chk_w("midrst", 0, 0, 0, 0);

    sel = 1;
    do_rst(2);
    for (int i = 0; i < 4; i++) begin
      run(16'h7fff, 16'h7fff, 1, lat, y, e);
      chk($sformatf("sat%0d_lat", i), lat, 10);
      chk($sformatf("sat%0d_y", i), y, sy[i]);
      chk($sformatf("sat%0d_e", i), e, se[i]);
      rd(0, v);
      chk($sformatf("sat%0d_w0", i), v, sw[i]);
    end

    do_rst(2);
    for (int i = 0; i < 5; i++) begin
      run(cx[i], cd[i], 1, lat, y, e);
      chk($sformatf("clip%0d_y", i), y, cy[i]);
      chk($sformatf("clip%0d_e", i), e, ce[i]);
    end
    chk_w("clip", 16'h8000, 16'hfffe, 16'h7ffd, 16'h7ffe);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lms_adapt_core.md
LMS_ADAPT_CORE -- requirements
Module: lms_adapt_core

Interface
REQ-001 SHALL have parameter DW, default 16, meaning the sample/weight width in signed Q1.(DW-1).
REQ-002 SHALL have parameter TAPS, default 16 (legal 2..64), meaning the FIR length and weight count.
REQ-003 SHALL have parameter MU_SHIFT, default 8, meaning step size mu = 2^-MU_SHIFT.
REQ-004 SHALL have port clk  in  1  meaning the sole clock; all logic on the rising edge.
REQ-005 SHALL have port rst_btn  in  1  meaning the synchronous, active-high reset.
REQ-006 SHALL have port in_valid  in  1  meaning x_in/d_in are presented.
REQ-007 SHALL have port in_ready  out  1  meaning the core accepts a sample this cycle.
REQ-008 SHALL have port x_in  in  DW  meaning the signed reference input sample.
REQ-009 SHALL have port d_in  in  DW  meaning the signed desired sample.
REQ-010 SHALL have port adapt_en  in  1  meaning weights update for this sample; sampled at accept.
REQ-011 SHALL have port w_clr  in  1  meaning clear all weights; honoured only in IDLE.
REQ-012 SHALL have port out_valid  out  1  meaning a one-cycle pulse that y_out/e_out are valid.
REQ-013 SHALL have port y_out  out  DW  meaning the signed filter output.
REQ-014 SHALL have port e_out  out  DW  meaning the signed error d - y.
REQ-015 SHALL have port coef_addr  in  clog2(TAPS)  meaning the weight readback index.
REQ-016 SHALL have port coef_data  out  DW  meaning w[coef_addr], registered with 1-cycle latency.

Function
REQ-017 SHALL implement FSM IDLE -> FILTER -> ERR -> UPDATE -> DONE -> IDLE; UPDATE is skipped (ERR -> DONE) when the latched adapt_en=0.
REQ-018 SHALL drive in_ready=1 only in IDLE; accept = in_valid && in_ready at cycle T.
REQ-019 SHALL on accept shift the delay line (x[0]<=x_in, x[k]<=x[k-1]) and latch d_in and adapt_en.
REQ-020 SHALL in FILTER spend exactly TAPS cycles (T+1..T+TAPS), one MAC per cycle, acc += w[k]*x[k], acc width 2*DW+clog2(TAPS), cleared at accept.
REQ-021 SHALL in ERR (T+TAPS+1) form y = sat_DW(acc >>> (DW-1)) and e = sat_DW(d - y), truncating and saturating to [-2^(DW-1), 2^(DW-1)-1].
REQ-022 SHALL in UPDATE spend exactly TAPS cycles, w[k] <= sat_DW(w[k] + ((e*x[k]) >>> (DW-1+MU_SHIFT))), k ascending.
REQ-023 SHALL in DONE assert out_valid for one cycle: at T+2*TAPS+2 with adaptation, or T+TAPS+2 without.
REQ-024 SHALL hold y_out/e_out stable from DONE until the next DONE.
REQ-025 SHALL ignore in_valid outside IDLE; no sample may be queued or dropped silently while in_ready=1.
REQ-026 SHALL give w_clr=1 in IDLE priority over accept: that cycle zeroes all weights, in_ready is low, and no sample is accepted.
REQ-027 SHALL never let any weight wrap; it saturates at the DW limits.

Reset
REQ-028 SHALL while rst_btn=1, in any state including mid-FILTER/UPDATE, return to IDLE next edge.
REQ-029 SHALL reset all weights, delay line, acc, y_out, e_out, coef_data to 0.
REQ-030 SHALL reset out_valid to 0; in_ready reads 0 during reset and 1 in the first cycle after release.

Verification
REQ-031 SHALL cover reset: rst_btn held 10 cycles -> out_valid=0, y_out=e_out=0, coef_data=0, in_ready=1 one cycle after release.
REQ-032 SHALL cover first update: TAPS=4, MU_SHIFT=1, accept x_in=0x4000, d_in=0x4000, adapt_en=1 -> out_valid at T+10, y_out=0x0000, e_out=0x4000, w[0]=0x1000, w[1..3]=0.
REQ-033 SHALL cover frozen mode: same stimulus with adapt_en=0 -> out_valid at T+6, all weights remain 0.
REQ-034 SHALL cover saturation: repeated x_in=0x7FFF, d_in=0x7FFF, MU_SHIFT=0 -> w[0] rises monotonically and stops at 0x7FFF, never negative; e_out never wraps.
REQ-035 SHALL cover busy/back-to-back: in_valid held high continuously -> exactly one accept per 2*TAPS+3 cycles, out_valid count equals accept count.
REQ-036 SHALL cover reset mid-UPDATE: rst_btn asserted at T+TAPS+3 -> no out_valid for that sample, all weights 0, IDLE next cycle.
